// File: rtl/ps2_poly_key_tracker_pkg.sv
// rtl/ps2_poly_key_tracker_pkg.sv - shared constants, prefix states and piano keymap
//
// Package ps2_piano_pkg: scan-code constants, prefix FSM state type, octave
// limits, the piano keymap and the octave-offset note helper.
// Optional feature macro used by the tracker: PS2_OCTAVE_SHIFT_EN.
package ps2_piano_pkg;

    localparam int CODE_W = 8;

    localparam logic [CODE_W-1:0] SC_BREAK = 8'hF0;
    localparam logic [CODE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [CODE_W-1:0] SC_UP    = 8'h75;
    localparam logic [CODE_W-1:0] SC_DOWN  = 8'h72;

    localparam logic [2:0] OCT_MIN     = 3'd0;
    localparam logic [2:0] OCT_NEUTRAL = 3'd2;
    localparam logic [2:0] OCT_MAX     = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } prefixState_t;

    // Bottom letter row is chromatic, the other rows walk a major scale.
    function automatic logic [7:0] keymap(input logic [CODE_W-1:0] scanCode);
        case (scanCode)
            8'h1A: keymap = 8'd1;   // z
            8'h22: keymap = 8'd2;   // x
            8'h21: keymap = 8'd3;   // c
            8'h2A: keymap = 8'd4;   // v
            8'h32: keymap = 8'd5;   // b
            8'h31: keymap = 8'd6;   // n
            8'h3A: keymap = 8'd7;   // m
            8'h1C: keymap = 8'd8;   // a
            8'h1B: keymap = 8'd10;  // s
            8'h23: keymap = 8'd12;  // d
            8'h2B: keymap = 8'd13;  // f
            8'h34: keymap = 8'd15;  // g
            8'h33: keymap = 8'd17;  // h
            8'h3B: keymap = 8'd19;  // j
            8'h15: keymap = 8'd20;  // q
            8'h1D: keymap = 8'd22;  // w
            8'h24: keymap = 8'd24;  // e
            8'h2D: keymap = 8'd25;  // r
            8'h2C: keymap = 8'd27;  // t
            8'h35: keymap = 8'd29;  // y
            8'h3C: keymap = 8'd31;  // u
            8'h43: keymap = 8'd32;  // i
            8'h44: keymap = 8'd34;  // o
            8'h4D: keymap = 8'd36;  // p
            8'h16: keymap = 8'd32;  // 1
            8'h1E: keymap = 8'd34;  // 2
            8'h26: keymap = 8'd36;  // 3
            8'h25: keymap = 8'd37;  // 4
            8'h2E: keymap = 8'd39;  // 5
            8'h36: keymap = 8'd41;  // 6
            8'h3D: keymap = 8'd43;  // 7
            8'h3E: keymap = 8'd44;  // 8
            8'h46: keymap = 8'd46;  // 9
            8'h45: keymap = 8'd48;  // 0
            default: keymap = 8'd0;
        endcase
    endfunction

    // key + 12*(octave-2), clamped to the playable range 1..127.
    function automatic logic [6:0] octaveNote(input logic [7:0] key, input logic [2:0] octave);
        logic signed [9:0] raw;
        raw = $signed({2'b00, key}) + $signed(10'd12) * ($signed({7'b0, octave}) - 10'sd2);
        if (raw < 10'sd1)
            octaveNote = 7'd1;
        else if (raw > 10'sd127)
            octaveNote = 7'd127;
        else
            octaveNote = raw[6:0];
    endfunction

endpackage

// File: rtl/ps2_poly_key_tracker_if.sv
// rtl/ps2_poly_key_tracker_if.sv - byte input and voice output bundle of the key tracker
//
// Signals: iFlag/iData (byte strobe and scan code from the PS/2 receiver),
// oNotes/oValid/oActive (per-slot notes, slot-held flags, held count),
// oEvent (slot or octave change pulse), oOctave (octave offset, 2 = neutral).
// master: byte source / voice consumer. slave: the tracker.
interface ps2_poly_key_tracker_if
    import ps2_piano_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 8
);
    logic                         iFlag;
    logic [CODE_W-1:0]            iData;
    logic [NUM_VOICES*NOTE_W-1:0] oNotes;
    logic [NUM_VOICES-1:0]        oValid;
    logic [3:0]                   oActive;
    logic                         oEvent;
    logic [2:0]                   oOctave;

    modport master (
        output iFlag, iData,
        input  oNotes, oValid, oActive, oEvent, oOctave
    );

    modport slave (
        input  iFlag, iData,
        output oNotes, oValid, oActive, oEvent, oOctave
    );
endinterface

// File: rtl/ps2_poly_key_tracker_voice_alloc.sv
// rtl/ps2_poly_key_tracker_voice_alloc.sv - voice slot table with allocation, stealing and aging
//
// Module ps2_voice_alloc.
// Ports: iClk, iReset (sync, active-high), iMake/iBreak (one-cycle requests),
// iCode (scan code), iNote (note for a make), oNotes/oValid (registered slots),
// oActive (held count), oChange (a slot changes on the next edge).
module ps2_voice_alloc
    import ps2_piano_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int NOTE_W       = 8,
    parameter int STEAL_OLDEST = 1,
    parameter int AGE_W        = 3
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iMake,
    input  logic                         iBreak,
    input  logic [CODE_W-1:0]            iCode,
    input  logic [NOTE_W-1:0]            iNote,
    output logic [NUM_VOICES*NOTE_W-1:0] oNotes,
    output logic [NUM_VOICES-1:0]        oValid,
    output logic [3:0]                   oActive,
    output logic                         oChange
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [CODE_W-1:0] slotCode [NUM_VOICES];
    logic [NOTE_W-1:0] slotNote [NUM_VOICES];
    logic [AGE_W-1:0]  slotAge  [NUM_VOICES];
    logic [NUM_VOICES-1:0] slotValid;

    logic             matchHit, freeHit, doAlloc, doRelease;
    logic [IDX_W-1:0] matchIdx, freeIdx, oldestIdx, target;
    logic [AGE_W-1:0] oldestAge;

    always_comb begin
        matchHit = 1'b0;
        matchIdx = '0;
        freeHit  = 1'b0;
        freeIdx  = '0;
        // Walk downward so the lowest matching / free index wins.
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            if (slotValid[k] && slotCode[k] == iCode) begin
                matchHit = 1'b1;
                matchIdx = IDX_W'(k);
            end
            if (!slotValid[k]) begin
                freeHit = 1'b1;
                freeIdx = IDX_W'(k);
            end
        end
        // Strict compare walking upward keeps ties on the lowest index.
        oldestIdx = '0;
        oldestAge = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (slotAge[k] > oldestAge) begin
                oldestAge = slotAge[k];
                oldestIdx = IDX_W'(k);
            end
        end

        doAlloc = 1'b0;
        target  = freeIdx;
        if (iMake && !matchHit) begin
            if (freeHit) begin
                doAlloc = 1'b1;
            end else if (STEAL_OLDEST != 0) begin
                doAlloc = 1'b1;
                target  = oldestIdx;
            end
        end
        doRelease = iBreak && matchHit;
        oChange   = doAlloc || doRelease;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            slotValid <= '0;
            for (int k = 0; k < NUM_VOICES; k++) begin
                slotCode[k] <= '0;
                slotNote[k] <= '0;
                slotAge[k]  <= '0;
            end
        end else if (doAlloc) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                if (target == IDX_W'(k)) begin
                    slotValid[k] <= 1'b1;
                    slotCode[k]  <= iCode;
                    slotNote[k]  <= iNote;
                    slotAge[k]   <= '0;
                end else if (slotValid[k] && slotAge[k] != '1) begin
                    slotAge[k] <= slotAge[k] + 1'b1;
                end
            end
        end else if (doRelease) begin
            slotValid[matchIdx] <= 1'b0;
            slotCode[matchIdx]  <= '0;
            slotNote[matchIdx]  <= '0;
            slotAge[matchIdx]   <= '0;
        end
    end

    always_comb begin
        oNotes  = '0;
        oActive = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            oNotes[k*NOTE_W +: NOTE_W] = slotNote[k];
            oActive = oActive + {3'b000, slotValid[k]};
        end
    end

    assign oValid = slotValid;

endmodule

// File: rtl/ps2_poly_key_tracker.sv
// rtl/ps2_poly_key_tracker.sv - polyphonic PS/2 scan-code key tracker
//
// Ports: iClk, iReset (sync, active-high), bus (slave side of
// ps2_poly_key_tracker_if: iFlag/iData in; oNotes/oValid/oActive/oEvent/oOctave out).
// Holds the make/break/extended prefix FSM, keymap lookup and the octave
// register; slot storage lives in ps2_voice_alloc.
// Optional feature macro: PS2_OCTAVE_SHIFT_EN (E0 75 / E0 72 move the octave).
module ps2_poly_key_tracker
    import ps2_piano_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int NOTE_W       = 8,
    parameter int STEAL_OLDEST = 1,
    parameter int AGE_W        = 3
) (
    input logic iClk,
    input logic iReset,
    ps2_poly_key_tracker_if.slave bus
);
    prefixState_t state, stateNext;
    logic         makeStb, breakStb, extMakeStb;
    logic [7:0]   keyNote;
    logic [2:0]   octave;
    logic         octChange, slotChange, eventReg;
    logic [NOTE_W-1:0] noteIn;
    logic [NUM_VOICES*NOTE_W-1:0] notesFlat;
    logic [NUM_VOICES-1:0] validFlat;
    logic [3:0] activeCount;

    always_ff @(posedge iClk) begin
        if (iReset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        makeStb    = 1'b0;
        breakStb   = 1'b0;
        extMakeStb = 1'b0;
        if (bus.iFlag) begin
            case (state)
                IDLE: begin
                    if (bus.iData == SC_BREAK)
                        stateNext = BRK;
                    else if (bus.iData == SC_EXT)
                        stateNext = EXT;
                    else
                        makeStb = 1'b1;
                end
                BRK: begin
                    breakStb  = 1'b1;
                    stateNext = IDLE;
                end
                EXT: begin
                    if (bus.iData == SC_BREAK) begin
                        stateNext = EXT_BRK;
                    end else begin
                        extMakeStb = 1'b1;
                        stateNext  = IDLE;
                    end
                end
                EXT_BRK: stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    assign keyNote = keymap(bus.iData);
    // Held notes keep the value computed at press time; only new makes see
    // the current octave.
    assign noteIn  = NOTE_W'(octaveNote(keyNote, octave));

`ifdef PS2_OCTAVE_SHIFT_EN
    logic octUp, octDown;
    assign octUp     = extMakeStb && bus.iData == SC_UP   && octave != OCT_MAX;
    assign octDown   = extMakeStb && bus.iData == SC_DOWN && octave != OCT_MIN;
    assign octChange = octUp || octDown;

    always_ff @(posedge iClk) begin
        if (iReset)
            octave <= OCT_NEUTRAL;
        else if (octUp)
            octave <= octave + 3'd1;
        else if (octDown)
            octave <= octave - 3'd1;
    end
`else
    logic unusedExtMake;
    assign unusedExtMake = extMakeStb;
    assign octave        = OCT_NEUTRAL;
    assign octChange     = 1'b0;
`endif

    ps2_voice_alloc #(
        .NUM_VOICES  (NUM_VOICES),
        .NOTE_W      (NOTE_W),
        .STEAL_OLDEST(STEAL_OLDEST),
        .AGE_W       (AGE_W)
    ) voiceAlloc (
        .iClk   (iClk),
        .iReset (iReset),
        .iMake  (makeStb && keyNote != 8'd0),
        .iBreak (breakStb),
        .iCode  (bus.iData),
        .iNote  (noteIn),
        .oNotes (notesFlat),
        .oValid (validFlat),
        .oActive(activeCount),
        .oChange(slotChange)
    );

    always_ff @(posedge iClk) begin
        if (iReset)
            eventReg <= 1'b0;
        else
            eventReg <= slotChange || octChange;
    end

    assign bus.oNotes  = notesFlat;
    assign bus.oValid  = validFlat;
    assign bus.oActive = activeCount;
    assign bus.oEvent  = eventReg;
    assign bus.oOctave = octave;

endmodule

// File: tb/tb_ps2_poly_key_tracker.sv
// tb/tb_ps2_poly_key_tracker.sv - self-checking bench for ps2_poly_key_tracker
module tb_ps2_poly_key_tracker;
    localparam int NV = 4;
    localparam int NW = 8;
    localparam int AGE_MAX = 7;
`ifdef PS2_OCTAVE_SHIFT_EN
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam bit SHIFT_ON = 1'b0;
`endif

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    always #5 iClk = ~iClk;

    ps2_poly_key_tracker_if #(.NUM_VOICES(NV), .NOTE_W(NW)) busA ();
    ps2_poly_key_tracker_if #(.NUM_VOICES(NV), .NOTE_W(NW)) busB ();

    ps2_poly_key_tracker #(.NUM_VOICES(NV), .NOTE_W(NW), .STEAL_OLDEST(1), .AGE_W(3))
        dutA (.iClk(iClk), .iReset(iReset), .bus(busA));
    ps2_poly_key_tracker #(.NUM_VOICES(NV), .NOTE_W(NW), .STEAL_OLDEST(0), .AGE_W(3))
        dutB (.iClk(iClk), .iReset(iReset), .bus(busB));

    int vectors = 0;
    int miscompares = 0;

    // Reference keymap built from the keyboard layout: scan codes per row.
    int km [256];
    int majorStep [7] = '{2, 2, 1, 2, 2, 2, 1};

    task automatic fillRow(input logic [79:0] codes, input int count, input int base, input bit chromatic);
        int n;
        n = base;
        for (int i = 0; i < count; i++) begin
            km[codes[79-8*i -: 8]] = n;
            n += chromatic ? 1 : majorStep[i % 7];
        end
    endtask

    // Behavioural model: one slot table per DUT, shared prefix/octave.
    int  mCode  [2][NV];
    int  mNote  [2][NV];
    bit  mValid [2][NV];
    int  mStamp [2][NV];
    int  mAllocs[2];
    bit  mEvt   [2];
    bit  stealCfg [2] = '{1'b1, 1'b0};
    bit  mExt, mBrk;
    int  mOct;
    bit  modelReady = 1'b0;

    function automatic int clampNote(input int n);
        return (n < 1) ? 1 : ((n > 127) ? 127 : n);
    endfunction

    task automatic modelReset();
        mExt = 0; mBrk = 0; mOct = 2;
        for (int d = 0; d < 2; d++) begin
            mAllocs[d] = 0; mEvt[d] = 0;
            for (int k = 0; k < NV; k++) begin
                mCode[d][k] = 0; mNote[d][k] = 0; mValid[d][k] = 0; mStamp[d][k] = 0;
            end
        end
    endtask

    task automatic modelMake(input int d, input int c);
        int note, tgt, bestAge, a;
        if (km[c] == 0) return;
        note = clampNote(km[c] + 12 * (mOct - 2));
        for (int k = 0; k < NV; k++)
            if (mValid[d][k] && mCode[d][k] == c) return;
        tgt = -1;
        for (int k = 0; k < NV; k++)
            if (!mValid[d][k] && tgt < 0) tgt = k;
        if (tgt < 0) begin
            if (!stealCfg[d]) return;
            bestAge = -1;
            for (int k = 0; k < NV; k++) begin
                a = mAllocs[d] - mStamp[d][k];
                if (a > AGE_MAX) a = AGE_MAX;
                if (a > bestAge) begin bestAge = a; tgt = k; end
            end
        end
        mAllocs[d]++;
        mStamp[d][tgt] = mAllocs[d];
        mCode[d][tgt] = c; mNote[d][tgt] = note; mValid[d][tgt] = 1;
        mEvt[d] = 1;
    endtask

    task automatic modelBreak(input int d, input int c);
        for (int k = 0; k < NV; k++)
            if (mValid[d][k] && mCode[d][k] == c) begin
                mValid[d][k] = 0; mCode[d][k] = 0; mNote[d][k] = 0;
                mEvt[d] = 1;
            end
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (mBrk) begin
            if (!mExt) for (int d = 0; d < 2; d++) modelBreak(d, int'(b));
            mBrk = 0; mExt = 0;
        end else if (mExt) begin
            if (b == 8'hF0) mBrk = 1;
            else begin
`ifdef PS2_OCTAVE_SHIFT_EN
                if (b == 8'h75 && mOct < 4) begin mOct++; mEvt[0] = 1; mEvt[1] = 1; end
                else if (b == 8'h72 && mOct > 0) begin mOct--; mEvt[0] = 1; mEvt[1] = 1; end
`endif
                mExt = 0;
            end
        end else if (b == 8'hF0) mBrk = 1;
        else if (b == 8'hE0) mExt = 1;
        else for (int d = 0; d < 2; d++) modelMake(d, int'(b));
    endtask

    task automatic checkDut(input int d);
        logic [NV*NW-1:0] eN, aN;
        logic [NV-1:0] eV, aV;
        logic [3:0] eA, aA;
        logic eE, aE;
        logic [2:0] eO, aO;
        eN = '0; eV = '0; eA = '0;
        for (int k = 0; k < NV; k++) begin
            eN[k*NW +: NW] = mValid[d][k] ? NW'(mNote[d][k]) : '0;
            eV[k] = mValid[d][k];
            eA = eA + 4'(mValid[d][k]);
        end
        eE = mEvt[d]; eO = 3'(mOct);
        if (d == 0) begin aN = busA.oNotes; aV = busA.oValid; aA = busA.oActive; aE = busA.oEvent; aO = busA.oOctave; end
        else        begin aN = busB.oNotes; aV = busB.oValid; aA = busB.oActive; aE = busB.oEvent; aO = busB.oOctave; end
        vectors++;
        if ({aN, aV, aA, aE, aO} !== {eN, eV, eA, eE, eO}) begin
            miscompares++;
            $display("FAIL model dut%0d t=%0t: got notes=%h valid=%b active=%0d event=%b octave=%0d, want notes=%h valid=%b active=%0d event=%b octave=%0d",
                     d, $time, aN, aV, aA, aE, aO, eN, eV, eA, eE, eO);
        end
    endtask

    // One clock: check what the previous cycle produced, then drive the next inputs.
    task automatic stepIn(input bit rst, input bit flag, input logic [7:0] data);
        @(negedge iClk);
        if (modelReady) begin checkDut(0); checkDut(1); end
        iReset = rst;
        busA.iFlag = flag; busA.iData = data;
        busB.iFlag = flag; busB.iData = data;
        mEvt[0] = 0; mEvt[1] = 0;
        if (rst) begin modelReset(); modelReady = 1; end
        else if (flag) modelByte(data);
    endtask

    task automatic handCheck(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    typedef struct {
        bit rst; bit flag; logic [7:0] data;
        logic [31:0] nA; logic [3:0] vA; bit eA;
        logic [31:0] nB; logic [3:0] vB; bit eB;
    } vec_t;
    vec_t tbl[$];

    task automatic addVec(input bit r, input bit f, input logic [7:0] dt,
                          input logic [31:0] nA, input logic [3:0] vA, input bit eA,
                          input logic [31:0] nB, input logic [3:0] vB, input bit eB);
        vec_t v;
        v.rst = r; v.flag = f; v.data = dt;
        v.nA = nA; v.vA = vA; v.eA = eA; v.nB = nB; v.vB = vB; v.eB = eB;
        tbl.push_back(v);
    endtask

    task automatic addSame(input bit r, input bit f, input logic [7:0] dt,
                           input logic [31:0] n, input logic [3:0] v, input bit e);
        addVec(r, f, dt, n, v, e, n, v, e);
    endtask

    task automatic checkTable(input int i);
        logic [3:0] actA, actB;
        actA = 4'($countones(tbl[i].vA));
        actB = 4'($countones(tbl[i].vB));
        vectors += 2;
        if ({busA.oNotes, busA.oValid, busA.oActive, busA.oEvent, busA.oOctave} !==
            {tbl[i].nA, tbl[i].vA, actA, tbl[i].eA, 3'd2}) begin
            miscompares++;
            $display("FAIL table[%0d] dutA: got notes=%h valid=%b active=%0d event=%b octave=%0d, want notes=%h valid=%b active=%0d event=%b octave=2",
                     i, busA.oNotes, busA.oValid, busA.oActive, busA.oEvent, busA.oOctave, tbl[i].nA, tbl[i].vA, actA, tbl[i].eA);
        end
        if ({busB.oNotes, busB.oValid, busB.oActive, busB.oEvent, busB.oOctave} !==
            {tbl[i].nB, tbl[i].vB, actB, tbl[i].eB, 3'd2}) begin
            miscompares++;
            $display("FAIL table[%0d] dutB: got notes=%h valid=%b active=%0d event=%b octave=%0d, want notes=%h valid=%b active=%0d event=%b octave=2",
                     i, busB.oNotes, busB.oValid, busB.oActive, busB.oEvent, busB.oOctave, tbl[i].nB, tbl[i].vB, actB, tbl[i].eB);
        end
    endtask

    function automatic logic [7:0] pickByte();
        logic [7:0] pool [8] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h1C, 8'h15, 8'h45};
        int r;
        r = $urandom_range(0, 15);
        if (r < 3) return 8'hF0;
        if (r < 5) return 8'hE0;
        if (r == 5) return 8'h75;
        if (r == 6) return 8'h72;
        if (r == 7) return 8'h0E;
        if (r == 8) return 8'($urandom_range(0, 255));
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        bit r, f;
        logic [7:0] b;
        busA.iFlag = 0; busA.iData = 0; busB.iFlag = 0; busB.iData = 0;
        for (int i = 0; i < 256; i++) km[i] = 0;
        fillRow(80'h1A_22_21_2A_32_31_3A_00_00_00, 7, 1, 1'b1);
        fillRow(80'h1C_1B_23_2B_34_33_3B_00_00_00, 7, 8, 1'b0);
        fillRow(80'h15_1D_24_2D_2C_35_3C_43_44_4D, 10, 20, 1'b0);
        fillRow(80'h16_1E_26_25_2E_36_3D_3E_46_45, 10, 32, 1'b0);
        modelReset();

        addSame(1, 0, 8'h00, 32'h0, 4'b0000, 0);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 1);
        addSame(0, 0, 8'h00, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'hF0, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'h1C, 32'h0, 4'b0000, 1);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 1);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'hF0, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'h1C, 32'h0, 4'b0000, 1);
        addSame(0, 1, 8'h1A, 32'h00000001, 4'b0001, 1);
        addSame(0, 1, 8'h22, 32'h00000201, 4'b0011, 1);
        addSame(0, 1, 8'h21, 32'h00030201, 4'b0111, 1);
        addSame(0, 1, 8'h2A, 32'h04030201, 4'b1111, 1);
        addVec (0, 1, 8'h32, 32'h04030205, 4'b1111, 1, 32'h04030201, 4'b1111, 0);
        addVec (0, 1, 8'hF0, 32'h04030205, 4'b1111, 0, 32'h04030201, 4'b1111, 0);
        addVec (0, 1, 8'h1A, 32'h04030205, 4'b1111, 0, 32'h04030200, 4'b1110, 1);
        addSame(1, 0, 8'h00, 32'h0, 4'b0000, 0);
        addSame(0, 1, 8'h1A, 32'h00000001, 4'b0001, 1);
        addSame(0, 1, 8'h22, 32'h00000201, 4'b0011, 1);
        addSame(0, 1, 8'hF0, 32'h00000201, 4'b0011, 0);
        addSame(0, 1, 8'h1A, 32'h00000200, 4'b0010, 1);
        addSame(0, 1, 8'h21, 32'h00000203, 4'b0011, 1);
        addSame(0, 1, 8'h0E, 32'h00000203, 4'b0011, 0);
        addSame(0, 1, 8'hF0, 32'h00000203, 4'b0011, 0);
        addSame(1, 0, 8'h00, 32'h0, 4'b0000, 0);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 1);
        addSame(0, 1, 8'hE0, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'hF0, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 0);
        addSame(0, 1, 8'h1C, 32'h00000008, 4'b0001, 0);
        addSame(0, 0, 8'h00, 32'h00000008, 4'b0001, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            stepIn(tbl[i].rst, tbl[i].flag, tbl[i].data);
            @(posedge iClk); #1;
            checkTable(i);
        end

        // Octave shift sequences.
        stepIn(1, 0, 8'h00);
        stepIn(0, 1, 8'hE0);
        stepIn(0, 1, 8'h75);
        @(posedge iClk); #1;
        handCheck("octUpEvent", 32'(busA.oEvent), SHIFT_ON ? 32'd1 : 32'd0);
        handCheck("octUp", 32'(busA.oOctave), SHIFT_ON ? 32'd3 : 32'd2);
        stepIn(0, 1, 8'h1C);
        @(posedge iClk); #1;
        handCheck("octNote", 32'(busA.oNotes[7:0]), SHIFT_ON ? 32'd20 : 32'd8);
        for (int i = 0; i < 5; i++) begin
            stepIn(0, 1, 8'hE0);
            stepIn(0, 1, 8'h75);
        end
        @(posedge iClk); #1;
        handCheck("octSatHigh", 32'(busA.oOctave), SHIFT_ON ? 32'd4 : 32'd2);
        handCheck("heldNoteKept", 32'(busA.oNotes[7:0]), SHIFT_ON ? 32'd20 : 32'd8);
        stepIn(0, 1, 8'hF0);
        stepIn(0, 1, 8'h1C);
        @(posedge iClk); #1;
        handCheck("releaseAfterShift", 32'(busA.oValid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            stepIn(0, 1, 8'hE0);
            stepIn(0, 1, 8'h72);
        end
        @(posedge iClk); #1;
        handCheck("octSatLow", 32'(busA.oOctave), SHIFT_ON ? 32'd0 : 32'd2);
        stepIn(0, 1, 8'h1A);
        stepIn(0, 1, 8'h45);
        @(posedge iClk); #1;
        handCheck("clampLow", 32'(busA.oNotes[7:0]), 32'd1);
        handCheck("octDownNote", 32'(busA.oNotes[15:8]), SHIFT_ON ? 32'd24 : 32'd48);

        // Random byte stream against the model, flag sometimes held for bursts.
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 99) < 60);
            b = pickByte();
            stepIn(r, f, b);
        end
        stepIn(0, 0, 8'h00);
        @(negedge iClk);
        checkDut(0);
        checkDut(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
